// File: rtl/pipeline_loader_pkg.sv
// rtl/pipeline_loader_pkg.sv - command codes, FSM states and widths for the pipeline loader
package pipeline_loader_pkg;

    localparam int LOADER_CNT_W = 16;

    localparam logic [7:0] CMD_LOAD_IMEM = 8'hA1;
    localparam logic [7:0] CMD_LOAD_DMEM = 8'hA2;
    localparam logic [7:0] CMD_RUN       = 8'hA3;
    localparam logic [7:0] CMD_HALT      = 8'hA4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_RUN    = 3'd5,
        ST_CKSUM  = 3'd6
    } state_t;

    typedef enum logic {
        TGT_IMEM = 1'b0,
        TGT_DMEM = 1'b1
    } target_t;

endpackage

// File: rtl/pipeline_loader_if.sv
// rtl/pipeline_loader_if.sv - byte stream handshake between a boot source and the loader
interface pipeline_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pipeline_loader_word_assembler.sv
// rtl/pipeline_loader_word_assembler.sv - shifts bytes into little-endian 32-bit words
module pipeline_loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_data,
    output logic [1:0]  byte_idx,
    output logic        word_valid
);

    // Shift bytes in from the top so byte0 ends up in bits [7:0]; pulse word_valid after byte 3.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_data  <= 32'd0;
            byte_idx   <= 2'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_en && (byte_idx == 2'd3);
            if (byte_en) begin
                word_data <= {byte_data, word_data[31:8]};
                byte_idx  <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/pipeline_loader.sv
// rtl/pipeline_loader.sv - byte-stream boot loader for IMEM/DMEM with run control; optional LOADER_CHECKSUM_EN
module pipeline_loader
    import pipeline_loader_pkg::*;
#(
    parameter int         IMEM_DEPTH = 512,
    parameter int         DMEM_DEPTH = 256,
    parameter logic [8:0] HALT_PC    = 9'd48
) (
    input  logic              clk,
    input  logic              reset,
    pipeline_loader_if.slave  src,
    input  logic [8:0]        pc,
    output logic              imem_we,
    output logic [8:0]        imem_addr,
    output logic [31:0]       imem_data,
    output logic              dmem_we_external,
    output logic [7:0]        dmem_addr,
    output logic [31:0]       dmem_data,
    output logic              pipe_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t FRAME_END = ST_CKSUM;
`else
    localparam state_t FRAME_END = ST_IDLE;
`endif

    state_t                  state, state_n;
    target_t                 target;
    logic [LOADER_CNT_W-1:0] word_cnt;
    logic [LOADER_CNT_W-1:0] word_idx;
    logic [7:0]              cnt_lo;
    logic                    hs;
    logic                    in_range;
    logic                    frame_last;
    logic                    err_set, done_set, done_clr;
    logic [31:0]             word_data;
    logic [1:0]              byte_idx;
    logic                    word_valid;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              cksum;
`endif

    assign src.in_ready = (state != ST_WRITE);
    assign hs           = src.in_valid && src.in_ready;
    assign frame_last   = (word_idx + 16'd1) == word_cnt;
    assign in_range     = (target == TGT_IMEM) ? (32'(word_idx) < IMEM_DEPTH)
                                               : (32'(word_idx) < DMEM_DEPTH);

    pipeline_loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (state == ST_IDLE),
        .byte_en    (hs && (state == ST_DATA)),
        .byte_data  (src.in_data),
        .word_data  (word_data),
        .byte_idx   (byte_idx),
        .word_valid (word_valid)
    );

    // Next-state decode plus the sticky-flag set/clear requests.
    always_comb begin
        state_n  = state;
        err_set  = 1'b0;
        done_set = 1'b0;
        done_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hs) begin
                    case (src.in_data)
                        CMD_LOAD_IMEM, CMD_LOAD_DMEM: begin
                            state_n  = ST_CNT_LO;
                            done_clr = 1'b1;
                        end
                        CMD_RUN: begin
                            state_n  = ST_RUN;
                            done_clr = 1'b1;
                        end
                        CMD_HALT: done_clr = 1'b1;
                        default:  err_set  = 1'b1;
                    endcase
                end
            end
            ST_CNT_LO: if (hs) state_n = ST_CNT_HI;
            ST_CNT_HI: begin
                if (hs) state_n = ({src.in_data, cnt_lo} == 16'd0) ? FRAME_END : ST_DATA;
            end
            ST_DATA: if (hs && (byte_idx == 2'd3)) state_n = ST_WRITE;
            ST_WRITE: begin
                if (!in_range) err_set = 1'b1;
                state_n = frame_last ? FRAME_END : ST_DATA;
            end
            ST_RUN: begin
                // Halt PC wins over any byte arriving in the same cycle.
                if (pc >= HALT_PC) begin
                    state_n  = ST_IDLE;
                    done_set = 1'b1;
                end else if (hs) begin
                    if (src.in_data == CMD_HALT) state_n = ST_IDLE;
                    else                         err_set = 1'b1;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CKSUM: begin
                if (hs) begin
                    if (src.in_data != cksum) err_set = 1'b1;
                    state_n = ST_IDLE;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    // State register, frame bookkeeping and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            target   <= TGT_IMEM;
            word_cnt <= '0;
            word_idx <= '0;
            cnt_lo   <= 8'd0;
            pipe_en  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state   <= state_n;
            pipe_en <= (state_n == ST_RUN);
            if (err_set) err <= 1'b1;
            if (done_set)      done <= 1'b1;
            else if (done_clr) done <= 1'b0;
            if (state == ST_IDLE) begin
                word_idx <= '0;
                if (hs) target <= (src.in_data == CMD_LOAD_DMEM) ? TGT_DMEM : TGT_IMEM;
            end
            if (state == ST_CNT_LO && hs) cnt_lo   <= src.in_data;
            if (state == ST_CNT_HI && hs) word_cnt <= {src.in_data, cnt_lo};
            if (state == ST_WRITE)        word_idx <= word_idx + 16'd1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every data byte in the current frame.
    always_ff @(posedge clk) begin
        if (reset || state == ST_IDLE) cksum <= 8'd0;
        else if (state == ST_DATA && hs) cksum <= cksum ^ src.in_data;
    end
`endif

    assign imem_we          = word_valid && (state == ST_WRITE) && (target == TGT_IMEM) && in_range;
    assign dmem_we_external = word_valid && (state == ST_WRITE) && (target == TGT_DMEM) && in_range;
    assign imem_addr        = word_idx[8:0];
    assign dmem_addr        = word_idx[7:0];
    assign imem_data        = word_data;
    assign dmem_data        = word_data;
    assign busy             = (state != ST_IDLE) && (state != ST_RUN);

endmodule
